// File: rtl/pio_in_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pio_in_capture: synchronized, debounced parallel input port with per-bit |
// | edge capture, maskable level interrupt and an Avalon-MM register view.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pio_in_capture #(
  parameter int unsigned      WIDTH     = 11,
  parameter int unsigned      DEBOUNCE  = 4,
  parameter int unsigned      EDGE_MODE = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0]            sync1_q, sync1_d;
  logic [WIDTH-1:0]            sync2_q, sync2_d;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]            edge_cap_q, edge_cap_d;
  logic [31:0]                 readdata_q, readdata_d;

  logic [WIDTH-1:0]            rise, fall, edge_evt, w1c;
  logic                        wr_en;
  logic                        unused_wdata;

  // Upper write-data bits beyond WIDTH carry no meaning.
  assign unused_wdata = ^writedata;

  // Debounce: a bit flips only after its counter would reach DEBOUNCE on
  // consecutive disagreeing samples; any agreement restarts qualification.
  always_comb begin
    sync1_d  = in_port;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    rise = stable_d & ~stable_q;
    fall = ~stable_d & stable_q;
    if (EDGE_MODE == 0) begin
      edge_evt = rise;
    end else if (EDGE_MODE == 1) begin
      edge_evt = fall;
    end else begin
      edge_evt = rise | fall;
    end
  end

  // New edge events win over a same-cycle write-1-to-clear.
  always_comb begin
    wr_en      = chipselect & ~write_n;
    w1c        = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    edge_cap_d = (edge_cap_q & ~w1c) | edge_evt;
    irq_mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irq_mask_q;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d = 32'(stable_q);
      2'd2:    readdata_d = 32'(irq_mask_q);
      2'd3:    readdata_d = 32'(edge_cap_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= RESET_VAL;
      cnt_q      <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule
`default_nettype wire
